slp_fxp_weight_bank: RTL and testbench
======================================

# slp_fxp_weight_bank

Sequential weight store and update sequencer for the single-layer perceptron fixed-point datapath. It holds N weights in registers and presents them in parallel to the forward-pass dot product. On a training request it latches one input vector and one error. It then walks the weights one per cycle through the external combinational weight-update datapath, which computes `weight + in*rate*error` and saturates/reduces to `W_CONF`. It writes back each result and accumulates sticky overflow, underflow and rounding flags.

## Interface
Parameters:
- `N`, 8, number of weights/inputs (≥2)
- `I_CONF`, `` `DEF_DCONF_FXP ``, input element format
- `P_CONF`, `` `DEF_DCONF_FXP ``, error format
- `W_CONF`, `` `DEF_DCONF_FXP ``, weight format
- `I_PREC`/`P_PREC`/`W_PREC`, `.prec` of the above; `IDX_W`, `$clog2(N)`

Ports:
- `clk` in 1: single clock
- `reset_` in 1: asynchronous, active-low reset
- `train_valid` in 1: training request
- `train_ready` out 1: high only in IDLE
- `in_vec` in N*I_PREC: input vector, element i at `[i*I_PREC +: I_PREC]`
- `error` in P_PREC: error for this pass
- `wr_en` in 1: host weight load
- `wr_idx` in IDX_W: host load index
- `wr_data` in W_PREC: host load value
- `upd_in` out I_PREC: latched `in_vec[idx]` to the datapath
- `upd_error` out P_PREC: latched error
- `upd_weight` out W_PREC: `weight[idx]`
- `upd_new_weight` in W_PREC: datapath result
- `upd_ovf` / `upd_udf` / `upd_rounded` in 1 each: datapath status
- `weight_vec` out N*W_PREC: all weights, same packing as `in_vec`
- `done` out 1: one-cycle pulse at end of pass
- `ovf_flag` / `udf_flag` / `rnd_flag` out 1 each: sticky status
- `clr_flags` in 1: clear sticky flags

## Operation
- FSM states `IDLE`, `UPDATE`, `DONE`.
  - `IDLE` → `UPDATE` on `train_valid && train_ready`. Latches `in_vec` and `error`, sets `idx` = 0.
  - `UPDATE`: each cycle writes `weight[idx] <= upd_new_weight` and ORs the status bits into the sticky flags. `idx` increments; after the write at `idx` = N-1 the FSM goes to `DONE`.
  - `DONE` → `IDLE` unconditionally; `done` = 1 in this state only.
- `upd_*` outputs are driven from the latched registers and `idx` in every state. They are valid for datapath use only in `UPDATE`.
- Host load applies only in `IDLE`: `weight[wr_idx] <= wr_data`.
  - `wr_idx ≥ N` is ignored.
  - `wr_en` outside `IDLE` is ignored.
- `wr_en` together with an accepted `train_valid` in the same `IDLE` cycle: the write takes effect at that edge, so the pass uses the written value.
- `clr_flags` in the same cycle as a flag-setting update: the set wins. Otherwise `clr_flags` clears all three flags.
- `train_valid` outside `IDLE` is not accepted. No queueing.

## Timing
- Reset values:
  - all weights 0, `weight_vec` 0
  - state `IDLE`, `idx` 0
  - latched input and error 0
  - `train_ready` 1
  - `done` 0
  - all flags 0
- Accept at edge k. Updates are written at edges k+1 … k+N. `done` is high in cycle k+N+1. `train_ready` returns at k+N+2.
- Back-to-back passes take one every N+2 cycles.
- `weight_vec` reflects each write the cycle after its edge. Partially updated vectors are visible during `UPDATE`.
- The datapath path `upd_* → upd_new_weight` is combinational within one cycle.
- Reset asserted mid-pass: immediate return to reset values. No `done`, weights zeroed.

## Configuration
- `SLP_WBANK_HOLD_ON_OVF_EN` defined: an update with `upd_ovf || upd_udf` does not write back; the weight keeps its old value. Flags are still set.
- Undefined: the datapath's saturated result is always written.

## Structure
- Add `wbank_state_t` (IDLE/UPDATE/DONE) to the shared perceptron package, next to `dconf_t`.
- Single module: FSM, index counter and register file are small enough to stay flat. No sub-module.

## Test plan
Bench config: N=4; `W_CONF` signed, 16-bit, 8 frac. Datapath model: `new = weight + 0x0010`, `upd_ovf` when the result exceeds 0x7FFF.
- Load weights 0x0100, 0x0200, 0x0300, 0x0400, then train → `weight_vec` = 0x0110, 0x0210, 0x0310, 0x0410. `done` in cycle k+5, flags 0.
- Weight[2] = 0x7FF8, model saturates with `upd_ovf` → `ovf_flag` = 1 and sticky across the next pass.
  - With `SLP_WBANK_HOLD_ON_OVF_EN`: weight[2] stays 0x7FF8.
  - Without: weight[2] = 0x7FFF.
- `wr_en` (idx 1, 0x0AAA) with `train_valid` in the same cycle → weight[1] = 0x0ABA. A `wr_en` issued during `UPDATE` is ignored.
- `train_valid` held high continuously → accepts every 6 cycles. `train_ready` is low during `UPDATE`/`DONE`.
- `reset_` low at cycle k+2 → all weights 0, `done` never pulses, `train_ready` = 1 immediately.
- `clr_flags` in the same cycle as an overflowing update → `ovf_flag` remains 1. `clr_flags` alone clears it.

Source files
------------

// File: rtl/slp_fxp_weight_bank_pkg.sv
// ---------------------------------------------------------------------------
// slp_fxp_weight_bank_pkg
// Shared types for the single-layer perceptron fixed-point datapath.
//   dconf_t        : fixed-point data configuration (sign, total bits, frac bits)
//   wbank_state_t  : weight-bank update sequencer states
// Also provides `DEF_DCONF_FXP, the default signed Q8.8 (16-bit) format.
// ---------------------------------------------------------------------------
`ifndef DEF_DCONF_FXP
`define DEF_DCONF_FXP '{sgn: 1'b1, prec: 8'd16, frac: 8'd8}
`endif

package slp_fxp_weight_bank_pkg;

    // Fixed-point format descriptor; prec is the total word width in bits.
    typedef struct packed {
        logic       sgn;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    // Weight-bank sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } wbank_state_t;

endpackage

// File: rtl/slp_fxp_weight_bank.sv
// ---------------------------------------------------------------------------
// slp_fxp_weight_bank
// Holds N perceptron weights, presents them in parallel, and on a training
// request walks them one per cycle through an external combinational update
// datapath, writing each result back and collecting sticky status flags.
//
// Ports:
//   clk, reset_ (async, active-low)
//   train_valid / train_ready       : training request handshake (ready = IDLE)
//   in_vec, error                   : latched on accept
//   wr_en, wr_idx, wr_data          : host weight load, honoured in IDLE only
//   upd_in, upd_error, upd_weight   : operands to the update datapath
//   upd_new_weight, upd_ovf/udf/rounded : datapath result and status
//   weight_vec                      : all weights, element i at [i*W_PREC +: W_PREC]
//   done                            : one-cycle pulse at the end of a pass
//   ovf_flag, udf_flag, rnd_flag    : sticky status, cleared by clr_flags
//
// Build option: SLP_WBANK_HOLD_ON_OVF_EN -- when defined, an update reporting
// overflow or underflow leaves the stored weight unchanged (flags still set).
// ---------------------------------------------------------------------------
module slp_fxp_weight_bank
    import slp_fxp_weight_bank_pkg::*;
#(
    parameter int     N      = 8,
    parameter dconf_t I_CONF = `DEF_DCONF_FXP,
    parameter dconf_t P_CONF = `DEF_DCONF_FXP,
    parameter dconf_t W_CONF = `DEF_DCONF_FXP,
    parameter int     I_PREC = int'(I_CONF.prec),
    parameter int     P_PREC = int'(P_CONF.prec),
    parameter int     W_PREC = int'(W_CONF.prec),
    parameter int     IDX_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                train_valid,
    output logic                train_ready,
    input  logic [N*I_PREC-1:0] in_vec,
    input  logic [P_PREC-1:0]   error,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [W_PREC-1:0]   wr_data,
    output logic [I_PREC-1:0]   upd_in,
    output logic [P_PREC-1:0]   upd_error,
    output logic [W_PREC-1:0]   upd_weight,
    input  logic [W_PREC-1:0]   upd_new_weight,
    input  logic                upd_ovf,
    input  logic                upd_udf,
    input  logic                upd_rounded,
    output logic [N*W_PREC-1:0] weight_vec,
    output logic                done,
    output logic                ovf_flag,
    output logic                udf_flag,
    output logic                rnd_flag,
    input  logic                clr_flags
);

    wbank_state_t       r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [I_PREC-1:0]  r_in     [N];
    logic [P_PREC-1:0]  r_error;
    logic [W_PREC-1:0]  r_weight [N];
    logic               r_train_ready;
    logic               r_done;
    logic               r_ovf;
    logic               r_udf;
    logic               r_rnd;

    logic               w_upd_active;
    logic               w_last;
    logic               w_commit;
    logic [N-1:0]       w_wr_sel;
    logic [N-1:0]       w_upd_sel;

    assign w_upd_active = (r_state == UPDATE);
    assign w_last       = (r_idx == IDX_W'(N - 1));

`ifdef SLP_WBANK_HOLD_ON_OVF_EN
    // Out-of-range results are discarded; the old weight is kept.
    assign w_commit = !(upd_ovf || upd_udf);
`else
    assign w_commit = 1'b1;
`endif

    // Per-weight write selects. An exact index match means wr_idx values of
    // N or above never select anything and are silently dropped.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel
            assign w_wr_sel[gi]  = (r_state == IDLE) && wr_en && (wr_idx == IDX_W'(gi));
            assign w_upd_sel[gi] = w_upd_active && w_commit && (r_idx == IDX_W'(gi));
            assign weight_vec[gi*W_PREC +: W_PREC] = r_weight[gi];
        end
    endgenerate

    // Weight register file. Host writes and datapath write-backs are mutually
    // exclusive by state, so the priority order here is only nominal.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < N; i++) begin
                r_weight[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_wr_sel[i]) begin
                    r_weight[i] <= wr_data;
                end else if (w_upd_sel[i]) begin
                    r_weight[i] <= upd_new_weight;
                end
            end
        end
    end

    // Sequencer: accept, walk indices 0..N-1, one DONE cycle, back to IDLE.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_error       <= '0;
            r_train_ready <= 1'b1;
            r_done        <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_in[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (train_valid && r_train_ready) begin
                        for (int i = 0; i < N; i++) begin
                            r_in[i] <= in_vec[i*I_PREC +: I_PREC];
                        end
                        r_error       <= error;
                        r_idx         <= '0;
                        r_state       <= UPDATE;
                        r_train_ready <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_state       <= IDLE;
                    r_done        <= 1'b0;
                    r_train_ready <= 1'b1;
                end
                default: begin
                    r_state       <= IDLE;
                    r_idx         <= '0;
                    r_done        <= 1'b0;
                    r_train_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clr_flags takes precedence.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_rnd <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !clr_flags) || (w_upd_active && upd_ovf);
            r_udf <= (r_udf && !clr_flags) || (w_upd_active && upd_udf);
            r_rnd <= (r_rnd && !clr_flags) || (w_upd_active && upd_rounded);
        end
    end

    assign upd_in      = r_in[r_idx];
    assign upd_error   = r_error;
    assign upd_weight  = r_weight[r_idx];
    assign train_ready = r_train_ready;
    assign done        = r_done;
    assign ovf_flag    = r_ovf;
    assign udf_flag    = r_udf;
    assign rnd_flag    = r_rnd;

endmodule

// File: tb/tb_slp_fxp_weight_bank.sv
// ---------------------------------------------------------------------------
// tb_slp_fxp_weight_bank
// Directed bench for slp_fxp_weight_bank with N=4 and signed 16-bit weights.
// The update datapath is modelled as new = weight + 0x0010, saturating at
// 0x7FFF with upd_ovf. Each accepted pass pushes its expected end state into
// a queue; a monitor pops and compares whenever done pulses.
// Honours SLP_WBANK_HOLD_ON_OVF_EN for the expected saturated weight.
// ---------------------------------------------------------------------------
module tb_slp_fxp_weight_bank;

    localparam int N  = 4;
    localparam int WP = 16;

`ifdef SLP_WBANK_HOLD_ON_OVF_EN
    localparam logic [15:0] W2_OVF = 16'h7FF8;
`else
    localparam logic [15:0] W2_OVF = 16'h7FFF;
`endif

    logic              clk = 1'b0;
    logic              reset_;
    logic              train_valid;
    logic              train_ready;
    logic [N*16-1:0]   in_vec;
    logic [15:0]       error;
    logic              wr_en;
    logic [1:0]        wr_idx;
    logic [15:0]       wr_data;
    logic [15:0]       upd_in;
    logic [15:0]       upd_error;
    logic [15:0]       upd_weight;
    logic [15:0]       upd_new_weight;
    logic              upd_ovf;
    logic              upd_udf;
    logic              upd_rounded;
    logic [N*WP-1:0]   weight_vec;
    logic              done;
    logic              ovf_flag;
    logic              udf_flag;
    logic              rnd_flag;
    logic              clr_flags;

    slp_fxp_weight_bank #(.N(N)) dut (
        .clk            (clk),
        .reset_         (reset_),
        .train_valid    (train_valid),
        .train_ready    (train_ready),
        .in_vec         (in_vec),
        .error          (error),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_data        (wr_data),
        .upd_in         (upd_in),
        .upd_error      (upd_error),
        .upd_weight     (upd_weight),
        .upd_new_weight (upd_new_weight),
        .upd_ovf        (upd_ovf),
        .upd_udf        (upd_udf),
        .upd_rounded    (upd_rounded),
        .weight_vec     (weight_vec),
        .done           (done),
        .ovf_flag       (ovf_flag),
        .udf_flag       (udf_flag),
        .rnd_flag       (rnd_flag),
        .clr_flags      (clr_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: +0x0010 with saturation at the positive limit.
    logic signed [16:0] dp_sum;
    always_comb begin
        dp_sum = $signed({upd_weight[15], upd_weight}) + 17'sd16;
        if (dp_sum > 17'sd32767) begin
            upd_new_weight = 16'h7FFF;
            upd_ovf        = 1'b1;
        end else begin
            upd_new_weight = dp_sum[15:0];
            upd_ovf        = 1'b0;
        end
    end
    assign upd_udf     = 1'b0;
    assign upd_rounded = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N*WP-1:0] wv;
        logic            ovf;
        int              done_cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("weight_vec", weight_vec, e.wv);
                check("ovf_flag", {63'd0, ovf_flag}, {63'd0, e.ovf});
                check("udf_flag", {63'd0, udf_flag}, 64'd0);
                check("rnd_flag", {63'd0, rnd_flag}, 64'd0);
                $display("pass done @%0d weight_vec=%h ovf=%b", cyc, weight_vec, ovf_flag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int idx, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_idx  = idx[1:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        $display("host write w[%0d]=%h", idx, d);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!train_ready && t < 50) begin
            tick();
            t++;
        end
        if (!train_ready) check("ready_timeout", {63'd0, train_ready}, 64'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((!train_ready || sb_q.size() != 0) && t < 100) begin
            tick();
            t++;
        end
        if (!train_ready || sb_q.size() != 0)
            check("idle_timeout", {62'd0, train_ready, sb_q.size() == 0}, 64'd3);
    endtask

    task automatic start_pass(input logic [N*WP-1:0] wv, input logic ovf, output int k);
        wait_ready();
        train_valid = 1'b1;
        tick();
        k = cyc;
        train_valid = 1'b0;
        sb_q.push_back('{wv, ovf, k + N});
        check("ready_low_after_accept", {63'd0, train_ready}, 64'd0);
        $display("train accepted @%0d", k);
    endtask

    initial begin
        int k;
        int k1;
        reset_      = 1'b0;
        train_valid = 1'b0;
        in_vec      = '0;
        error       = '0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;
        clr_flags   = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_weight_vec", weight_vec, 64'd0);
        check("rst_train_ready", {63'd0, train_ready}, 64'd1);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_flags", {61'd0, ovf_flag, udf_flag, rnd_flag}, 64'd0);
        check("rst_upd_in", {48'd0, upd_in}, 64'd0);
        check("rst_upd_error", {48'd0, upd_error}, 64'd0);
        reset_ = 1'b1;
        tick();

        // Basic pass, plus latching and UPDATE-time host write rejection
        host_write(0, 16'h0100);
        host_write(1, 16'h0200);
        host_write(2, 16'h0300);
        host_write(3, 16'h0400);
        in_vec = 64'h4444_3333_2222_1111;
        error  = 16'h0ABC;
        start_pass({16'h0410, 16'h0310, 16'h0210, 16'h0110}, 1'b0, k);
        check("upd_in_idx0", {48'd0, upd_in}, 64'h1111);
        check("upd_error", {48'd0, upd_error}, 64'h0ABC);
        check("upd_weight_idx0", {48'd0, upd_weight}, 64'h0100);
        in_vec = '0;
        error  = '0;
        tick();
        check("upd_in_idx1_latched", {48'd0, upd_in}, 64'h2222);
        check("upd_error_latched", {48'd0, upd_error}, 64'h0ABC);
        host_write(0, 16'hDEAD);
        check("partial_w0", {48'd0, weight_vec[15:0]}, 64'h0110);
        check("partial_w1", {48'd0, weight_vec[31:16]}, 64'h0210);
        check("partial_w2_old", {48'd0, weight_vec[47:32]}, 64'h0300);
        wait_idle();

        // Saturating update sets ovf
        host_write(2, 16'h7FF8);
        start_pass({16'h0420, W2_OVF, 16'h0220, 16'h0120}, 1'b1, k);
        wait_idle();

        // Clean pass: ovf stays sticky
        host_write(2, 16'h0500);
        start_pass({16'h0430, 16'h0510, 16'h0230, 16'h0130}, 1'b1, k);
        wait_idle();

        // clr_flags alone clears
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_alone", {63'd0, ovf_flag}, 64'd0);

        // clr_flags coinciding with the overflowing update: set wins
        host_write(2, 16'h7FF8);
        start_pass({16'h0440, W2_OVF, 16'h0240, 16'h0140}, 1'b1, k);
        tick();
        tick();
        check("ovf_before_idx2", {63'd0, ovf_flag}, 64'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("set_beats_clr", {63'd0, ovf_flag}, 64'd1);
        wait_idle();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("clr_alone_2", {63'd0, ovf_flag}, 64'd0);

        // Host write in the accepting cycle feeds the pass
        host_write(2, 16'h0100);
        wait_ready();
        wr_en       = 1'b1;
        wr_idx      = 2'd1;
        wr_data     = 16'h0AAA;
        train_valid = 1'b1;
        tick();
        k = cyc;
        wr_en       = 1'b0;
        train_valid = 1'b0;
        sb_q.push_back('{{16'h0450, 16'h0110, 16'h0ABA, 16'h0150}, 1'b0, k + N});
        $display("train accepted with host write @%0d", k);
        wait_idle();

        // train_valid held high: one accept every N+2 cycles
        wait_ready();
        k1 = cyc + 1;
        sb_q.push_back('{{16'h0460, 16'h0120, 16'h0ACA, 16'h0160}, 1'b0, k1 + N});
        sb_q.push_back('{{16'h0470, 16'h0130, 16'h0ADA, 16'h0170}, 1'b0, k1 + N + 6});
        sb_q.push_back('{{16'h0480, 16'h0140, 16'h0AEA, 16'h0180}, 1'b0, k1 + N + 12});
        train_valid = 1'b1;
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c <= N; c++) begin
                check("ready_low_busy", {63'd0, train_ready}, 64'd0);
                tick();
            end
            check("ready_high_idle", {63'd0, train_ready}, 64'd1);
            if (p == 2) train_valid = 1'b0;
            tick();
        end
        wait_idle();

        // Reset in the middle of a pass
        wait_ready();
        train_valid = 1'b1;
        tick();
        train_valid = 1'b0;
        tick();
        tick();
        check("midpass_busy", {63'd0, train_ready}, 64'd0);
        reset_ = 1'b0;
        #1;
        check("midrst_weight_vec", weight_vec, 64'd0);
        check("midrst_train_ready", {63'd0, train_ready}, 64'd1);
        check("midrst_done", {63'd0, done}, 64'd0);
        tick();
        tick();
        reset_ = 1'b1;
        repeat (N + 4) tick();
        check("post_rst_weight_vec", weight_vec, 64'd0);
        check("post_rst_ready", {63'd0, train_ready}, 64'd1);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
